mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port unified instruction/data memory between the multicycle core (requester 0) and an external program loader/debug port (requester 1). It sits between the core's `Data_path` memory interface, the loader, and the memory macro. It serialises accesses, generates byte enables and lane-replicated write data from the core's byte/half/word size, and rejects misaligned accesses without touching memory.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 36 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared FSM encoding, access-size codes and alignment helper for mem_arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arbState_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Width of the memory latency counter; MEM_LAT must fit in it.
  localparam int LAT_W = 8;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addrLo[0];
      SZ_WORD: return |addrLo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-enable and lane-replicated write data generation from access size and low address bits.
module mem_lane_align
  import arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         size,
  input  logic [1:0]         addrLo,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH/8-1:0] be,
  output logic [WIDTH-1:0]   wdataRep,
  output logic               misaligned
);

  localparam int BE_W = WIDTH / 8;

  always_comb begin
    be       = '0;
    wdataRep = wdata;
    case (size)
      SZ_BYTE: begin
        be       = BE_W'(1) << addrLo;
        wdataRep = {(WIDTH/8){wdata[7:0]}};
      end
      SZ_HALF: begin
        be       = BE_W'(3) << addrLo;
        wdataRep = {(WIDTH/16){wdata[15:0]}};
      end
      SZ_WORD: be = '1;
      default: be = '0;
    endcase
  end

  assign misaligned = isMisaligned(size, addrLo);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core (m0) and loader (m1) accesses onto one single-port memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise m0 has fixed priority.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [1:0]           m0_size,
  input  logic [ADDR_W-1:0]    m0_addr,
  input  logic [WIDTH-1:0]     m0_wdata,
  output logic                 m0_ack,
  output logic                 m0_err,
  output logic [WIDTH-1:0]     m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [1:0]           m1_size,
  input  logic [ADDR_W-1:0]    m1_addr,
  input  logic [WIDTH-1:0]     m1_wdata,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic [WIDTH-1:0]     m1_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [WIDTH/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int BE_W = WIDTH / 8;

  arbState_t         state;
  logic [LAT_W-1:0]  latCnt;
  logic              grantId;
  logic              ackReg;
  logic              errReg;
  logic [WIDTH-1:0]  rdataReg;
`ifdef ARB_ROUND_ROBIN_EN
  logic              lastGrant;
`endif

  logic              latWe;
  logic [1:0]        latSize;
  logic [ADDR_W-1:0] latAddr;
  logic [WIDTH-1:0]  latWdata;

  logic              anyReq;
  logic              winner;
  logic              winWe;
  logic [1:0]        winSize;
  logic [ADDR_W-1:0] winAddr;
  logic [WIDTH-1:0]  winWdata;

  logic [BE_W-1:0]   alignBe;
  logic [WIDTH-1:0]  alignWdata;
  logic              alignMis;
  logic              issueEn;

  assign anyReq = m0_req | m1_req;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    winner = (m0_req && m1_req) ? ~lastGrant : ~m0_req;
`else
    winner = ~m0_req;
`endif
  end

  assign winWe    = winner ? m1_we    : m0_we;
  assign winSize  = winner ? m1_size  : m0_size;
  assign winAddr  = winner ? m1_addr  : m0_addr;
  assign winWdata = winner ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      latCnt   <= '0;
      grantId  <= 1'b0;
      ackReg   <= 1'b0;
      errReg   <= 1'b0;
      rdataReg <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrant <= 1'b1;
`endif
    end else begin
      ackReg <= 1'b0;
      errReg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (anyReq) begin
            grantId <= winner;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrant <= winner;
`endif
            // Misaligned requests complete immediately with no memory access.
            if (isMisaligned(winSize, winAddr[1:0])) begin
              state  <= ST_DONE;
              ackReg <= 1'b1;
              errReg <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          latCnt <= LAT_W'(MEM_LAT);
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (latCnt == LAT_W'(1)) begin
            if (!latWe) rdataReg <= mem_rdata;
            ackReg <= 1'b1;
            state  <= ST_DONE;
          end else begin
            latCnt <= latCnt - LAT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request fields are captured once at grant; later changes are ignored.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && anyReq) begin
      latWe    <= winWe;
      latSize  <= winSize;
      latAddr  <= winAddr;
      latWdata <= winWdata;
    end
  end

  mem_lane_align #(.WIDTH(WIDTH)) uAlign (
    .size       (latSize),
    .addrLo     (latAddr[1:0]),
    .wdata      (latWdata),
    .be         (alignBe),
    .wdataRep   (alignWdata),
    .misaligned (alignMis)
  );

  assign issueEn   = (state == ST_ISSUE) && !alignMis;
  assign mem_en    = issueEn;
  assign mem_we    = issueEn & latWe;
  assign mem_be    = issueEn ? alignBe : '0;
  assign mem_addr  = issueEn ? {latAddr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = issueEn ? alignWdata : '0;

  assign busy     = (state != ST_IDLE);
  assign grant_id = grantId;

  assign m0_ack   = ackReg & ~grantId;
  assign m1_ack   = ackReg &  grantId;
  assign m0_err   = errReg & ~grantId;
  assign m1_err   = errReg &  grantId;
  assign m0_rdata = m0_ack ? rdataReg : '0;
  assign m1_rdata = m1_ack ? rdataReg : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed literal checks.
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, busy, grant_id;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.WIDTH(32), .ADDR_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro: registered read data held until the next access.
  logic [31:0] envMem [0:255];
  always @(posedge clk) begin
    if (mem_en && mem_we) envMem[mem_addr[9:2]] <= mergeBytes(envMem[mem_addr[9:2]], mem_wdata, mem_be);
    else if (mem_en) mem_rdata <= envMem[mem_addr[9:2]];
  end

  int passCnt = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---- transaction-level model ----
  logic [31:0] modelMem [0:255];
  logic        checkEn = 1'b0;
  logic        txnActive, txWin, txWe, txMis, gidPrev, lastGrantM;
  logic [1:0]  txSize;
  logic [31:0] txAddr, txWdata, lastRdata;
  int          t0, ackOff;

  function automatic logic modelMis(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] expBe(input logic [1:0] size, input logic [31:0] addr);
    int sh;
    sh = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << sh);
    if (size == 2'd1) return 4'(3 << sh);
    return 4'hF;
  endfunction

  function automatic logic [31:0] expWdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic pickWinner(input logic r0, input logic r1);
`ifdef ARB_ROUND_ROBIN_EN
    if (r0 && r1) return !lastGrantM;
`endif
    return r0 ? 1'b0 : 1'b1;
  endfunction

  task automatic launch();
    if (txnActive) gidPrev = txWin;
    txWin   = pickWinner(m0_req, m1_req);
    txWe    = txWin ? m1_we : m0_we;
    txSize  = txWin ? m1_size : m0_size;
    txAddr  = txWin ? m1_addr : m0_addr;
    txWdata = txWin ? m1_wdata : m0_wdata;
    txMis   = modelMis(txSize, txAddr);
    ackOff  = txMis ? 1 : 2 + LAT;
    t0 = cyc;
    txnActive = 1'b1;
    lastGrantM = txWin;
  endtask

  task automatic compareCycle();
    int off;
    logic eEn, eAck, eBusy, eGid;
    logic [31:0] rd;
    off   = cyc - t0;
    eBusy = txnActive && off >= 1 && off <= ackOff;
    eEn   = txnActive && !txMis && off == 1;
    eAck  = txnActive && off == ackOff;
    eGid  = (txnActive && off >= 1) ? txWin : gidPrev;
    check("busy", 32'(busy), 32'(eBusy));
    check("grant_id", 32'(grant_id), 32'(eGid));
    check("mem_en", 32'(mem_en), 32'(eEn));
    check("mem_we", 32'(mem_we), 32'(eEn && txWe));
    check("mem_be", 32'(mem_be), eEn ? 32'(expBe(txSize, txAddr)) : 32'h0);
    check("mem_addr", mem_addr, eEn ? (txAddr & ~32'h3) : 32'h0);
    check("mem_wdata", mem_wdata, eEn ? expWdata(txSize, txWdata) : 32'h0);
    check("m0_ack", 32'(m0_ack), 32'(eAck && !txWin));
    check("m1_ack", 32'(m1_ack), 32'(eAck && txWin));
    check("m0_err", 32'(m0_err), 32'(eAck && txMis && !txWin));
    check("m1_err", 32'(m1_err), 32'(eAck && txMis && txWin));
    if (eAck && !txMis) begin
      rd = txWe ? lastRdata : modelMem[txAddr[9:2]];
      check(txWin ? "m1_rdata" : "m0_rdata", txWin ? m1_rdata : m0_rdata, rd);
      check("loser_rdata", txWin ? m0_rdata : m1_rdata, 32'h0);
      if (txWe) modelMem[txAddr[9:2]] = mergeBytes(modelMem[txAddr[9:2]],
                                                   expWdata(txSize, txWdata), expBe(txSize, txAddr));
      else lastRdata = rd;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (checkEn) compareCycle();
  end

  // ---- stimulus ----
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drivePort(input int p, input logic req, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin m0_req = req; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wd; end
    else        begin m1_req = req; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wd; end
  endtask

  task automatic runTxn(input int p, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd);
    drivePort(p, 1'b1, we, size, addr, wd);
    launch();
    step(ackOff + 1);
    drivePort(p, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);
  endtask

  int          vP    [5] = '{1, 0, 1, 0, 1};
  logic        vWe   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0]  vSize [5] = '{2'd3, 2'd2, 2'd0, 2'd2, 2'd2};
  logic [31:0] vAddr [5] = '{32'h0, 32'h202, 32'h201, 32'h10, 32'h10};
  logic [31:0] vData [5] = '{32'h77, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
  logic        modelOrder [4];
  logic        dutOrder [4];
`ifdef ARB_ROUND_ROBIN_EN
  logic        expOrder [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
  logic        expOrder [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

  initial begin
    reset = 1'b1;
    drivePort(0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);
    drivePort(1, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) begin envMem[i] = 32'h0; modelMem[i] = 32'h0; end
    envMem[8'h80] = 32'hDEADBEEF;
    modelMem[8'h80] = 32'hDEADBEEF;
    mem_rdata = 32'h0;
    step(2);
    check("rst busy", 32'(busy), 32'h0);
    check("rst mem_en", 32'(mem_en), 32'h0);
    check("rst acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    check("rst grant_id", 32'(grant_id), 32'h0);
    check("rst rdata", m0_rdata | m1_rdata, 32'h0);
    txnActive = 1'b0; gidPrev = 1'b0; lastGrantM = 1'b1; lastRdata = 32'h0; t0 = 0; ackOff = 1;
    reset = 1'b0;
    checkEn = 1'b1;
    step(1);

    // Core byte write
    drivePort(0, 1'b1, 1'b1, 2'b00, 32'h103, 32'hA5);
    launch();
    step(1);
    check("byte mem_en", 32'(mem_en), 32'h1);
    check("byte mem_addr", mem_addr, 32'h100);
    check("byte mem_be", 32'(mem_be), 32'b1000);
    check("byte mem_wdata", mem_wdata, 32'hA5A5A5A5);
    step(LAT + 1);
    check("byte m0_ack", 32'(m0_ack), 32'h1);
    check("byte m0_err", 32'(m0_err), 32'h0);
    step(1);
    drivePort(0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);

    // Loader word read
    drivePort(1, 1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
    launch();
    step(2 + LAT);
    check("ldr m1_ack", 32'(m1_ack), 32'h1);
    check("ldr m1_rdata", m1_rdata, 32'hDEADBEEF);
    check("ldr m0_ack", 32'(m0_ack), 32'h0);
    step(1);
    drivePort(1, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);

    // Misaligned half read
    drivePort(0, 1'b1, 1'b0, 2'b01, 32'h001, 32'h0);
    launch();
    step(1);
    check("mis m0_ack", 32'(m0_ack), 32'h1);
    check("mis m0_err", 32'(m0_err), 32'h1);
    check("mis mem_en", 32'(mem_en), 32'h0);
    step(1);
    drivePort(0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);

    // Half write overlapping the earlier byte write
    drivePort(0, 1'b1, 1'b1, 2'b01, 32'h102, 32'h1234);
    launch();
    step(1);
    check("half mem_be", 32'(mem_be), 32'b1100);
    check("half mem_wdata", mem_wdata, 32'h12341234);
    step(LAT + 2);
    drivePort(0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);

    // Word read-back: half write replaced byte 3
    drivePort(0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    launch();
    step(2 + LAT);
    check("rb m0_rdata", m0_rdata, 32'h12340000);
    step(1);
    drivePort(0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);

    for (int i = 0; i < 5; i++) runTxn(vP[i], vWe[i], vSize[i], vAddr[i], vData[i]);

    // Request while busy is held off; mid-transaction field change ignored
    drivePort(0, 1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
    launch();
    step(2);
    drivePort(1, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    m0_addr = 32'h104;
    step(LAT);
    check("hold m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("hold m1_ack", 32'(m1_ack), 32'h0);
    step(1);
    drivePort(0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);
    launch();
    step(2 + LAT);
    check("hold m1_rdata", m1_rdata, 32'h12340000);
    step(1);
    drivePort(1, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);

    // Reset during WAIT drops the access
    drivePort(1, 1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
    launch();
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    drivePort(1, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);
    txnActive = 1'b0; gidPrev = 1'b0; lastGrantM = 1'b1; lastRdata = 32'h0;
    check("rstw busy", 32'(busy), 32'h0);
    check("rstw grant_id", 32'(grant_id), 32'h0);
    check("rstw m1_ack", 32'(m1_ack), 32'h0);
    check("rstw mem_en", 32'(mem_en), 32'h0);
    step(LAT + 2);

    // Simultaneous requests held for four transactions
    drivePort(0, 1'b1, 1'b1, 2'b10, 32'h300, 32'h0000AAAA);
    drivePort(1, 1'b1, 1'b1, 2'b10, 32'h304, 32'hBBBB0000);
    for (int i = 0; i < 4; i++) begin
      launch();
      modelOrder[i] = txWin;
      step(2 + LAT);
      check("tie ack seen", 32'(m0_ack | m1_ack), 32'h1);
      dutOrder[i] = m1_ack;
      step(1);
    end
    drivePort(0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);
    drivePort(1, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tie dut order %0d", i), 32'(dutOrder[i]), 32'(expOrder[i]));
      check($sformatf("tie model order %0d", i), 32'(modelOrder[i]), 32'(expOrder[i]));
    end
    step(3);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
